// File: rtl/mips_core_pkg.sv
// Shared types and helpers for the mips core memory path.
`include "mips_core.svh"
package mips_core_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wb_state_t;

  localparam int AXI_ID_W  = `AXI_ID_WIDTH;
  localparam int AXI_LEN_W = `AXI_LEN_WIDTH;

  // Clears the byte-offset bits below a line boundary.
  function automatic logic [`ADDR_WIDTH-1:0] line_base(input logic [`ADDR_WIDTH-1:0] addr,
                                                       input int off_w);
    logic [`ADDR_WIDTH-1:0] mask;
    mask = (`ADDR_WIDTH'(1) << off_w) - `ADDR_WIDTH'(1);
    return addr & ~mask;
  endfunction
endpackage

// File: rtl/axi_write_if.sv
// AXI3-style write channel bundles between bus masters and the memory arbiter.
`include "mips_core.svh"
interface axi_write_address;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [`AXI_ID_WIDTH-1:0]  AWID;
  logic [`AXI_LEN_WIDTH-1:0] AWLEN;
  logic [`ADDR_WIDTH-1:0]    AWADDR;
  modport master (output AWVALID, AWID, AWLEN, AWADDR, input AWREADY);
  modport slave  (input AWVALID, AWID, AWLEN, AWADDR, output AWREADY);
endinterface

interface axi_write_data;
  logic                     WVALID;
  logic                     WREADY;
  logic [`AXI_ID_WIDTH-1:0] WID;
  logic                     WLAST;
  logic [`DATA_WIDTH-1:0]   WDATA;
  modport master (output WVALID, WID, WLAST, WDATA, input WREADY);
  modport slave  (input WVALID, WID, WLAST, WDATA, output WREADY);
endinterface

interface axi_write_response;
  logic                     BVALID;
  logic                     BREADY;
  logic [`AXI_ID_WIDTH-1:0] BID;
  modport master (input BVALID, BID, output BREADY);
  modport slave  (output BVALID, BID, input BREADY);
endinterface

// File: rtl/mips_core.svh
// Core-wide width macros shared by the memory-side blocks.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define ADDR_WIDTH    32
`define DATA_WIDTH    32
`define AXI_ID_WIDTH  4
`define AXI_LEN_WIDTH 4
`endif

// File: rtl/writeback_fifo.sv
// Line storage for writeback_buffer: circular FIFO of dirty lines plus
// per-entry line comparators for the read-miss lookup.
`include "mips_core.svh"
module writeback_fifo
  import mips_core_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [`ADDR_WIDTH-1:0]            push_addr,
  input  logic [LINE_WORDS*`DATA_WIDTH-1:0] push_data,
  input  logic                              pop,
  output logic [`ADDR_WIDTH-1:0]            head_addr,
  output logic [LINE_WORDS*`DATA_WIDTH-1:0] head_data,
  output logic                              full,
  output logic                              empty,
  input  logic [`ADDR_WIDTH-1:0]            lookup_addr,
  output logic                              lookup_hit,
  output logic [LINE_WORDS*`DATA_WIDTH-1:0] lookup_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OFF_W = $clog2(LINE_WORDS * `DATA_WIDTH / 8);
  localparam int LW    = LINE_WORDS * `DATA_WIDTH;

  logic [DEPTH-1:0][`ADDR_WIDTH-1:0] ent_addr;
  logic [DEPTH-1:0][LW-1:0]          ent_data;
  logic [DEPTH-1:0]                  ent_vld;
  logic [DEPTH-1:0]                  match;
  logic [PTR_W-1:0]                  head, tail, idx;
  logic [PTR_W:0]                    sum;
  logic [CNT_W-1:0]                  count;
  logic [`ADDR_WIDTH-1:0]            lk_line;
  logic                              push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_addr = ent_addr[head];
  assign head_data = ent_data[head];
  assign lk_line   = line_base(lookup_addr, OFF_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_addr <= '0;
      ent_data <= '0;
      ent_vld  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push_ok) begin
        ent_addr[tail] <= line_base(push_addr, OFF_W);
        ent_data[tail] <= push_data;
        ent_vld[tail]  <= 1'b1;
        tail           <= ptr_inc(tail);
      end
      if (pop_ok) begin
        ent_vld[head] <= 1'b0;
        head          <= ptr_inc(head);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_match
    assign match[e] = ent_vld[e] && (ent_addr[e] == lk_line);
  end

`ifdef WRITEBACK_FORWARD_EN
  logic [LW-1:0] fwd;
  assign lookup_data = fwd;
`else
  assign lookup_data = '0;
`endif

  // Walk oldest to youngest so the last match seen is the youngest copy.
  always_comb begin
    lookup_hit = 1'b0;
    sum        = '0;
    idx        = '0;
`ifdef WRITEBACK_FORWARD_EN
    fwd        = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      sum = {1'b0, head} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(DEPTH)) sum = sum - (PTR_W+1)'(DEPTH);
      idx = sum[PTR_W-1:0];
      if (match[idx]) begin
        lookup_hit = 1'b1;
`ifdef WRITEBACK_FORWARD_EN
        fwd        = ent_data[idx];
`endif
      end
    end
  end
endmodule

// File: rtl/writeback_buffer.sv
// Posted-write buffer between d_cache evictions and an AXI write master.
// WRITEBACK_FORWARD_EN enables lookup_data forwarding of the youngest matching line.
`include "mips_core.svh"
module writeback_buffer
  import mips_core_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 2,
  parameter int WB_ID      = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wb_valid,
  output logic                              wb_ready,
  input  logic [`ADDR_WIDTH-1:0]            wb_addr,
  input  logic [LINE_WORDS*`DATA_WIDTH-1:0] wb_data,
  input  logic [`ADDR_WIDTH-1:0]            lookup_addr,
  output logic                              lookup_hit,
  output logic [LINE_WORDS*`DATA_WIDTH-1:0] lookup_data,
  axi_write_address.master                  mem_write_address,
  axi_write_data.master                     mem_write_data,
  axi_write_response.master                 mem_write_response
);
  localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

  wb_state_t                         state, state_nxt;
  logic [2:0]                        beat, beat_nxt;
  logic                              pop, full, empty;
  logic [`ADDR_WIDTH-1:0]            head_addr;
  logic [LINE_WORDS*`DATA_WIDTH-1:0] head_data;
  logic [`DATA_WIDTH-1:0]            wdata;
  logic                              unused_bid;

  assign wb_ready   = !full;
  assign unused_bid = ^mem_write_response.BID;

  writeback_fifo #(.LINE_WORDS(LINE_WORDS), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (wb_valid),
    .push_addr  (wb_addr),
    .push_data  (wb_data),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty),
    .lookup_addr(lookup_addr),
    .lookup_hit (lookup_hit),
    .lookup_data(lookup_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) state_nxt = ADDR;
      ADDR: begin
        beat_nxt = '0;
        if (mem_write_address.AWREADY) state_nxt = DATA;
      end
      DATA: if (mem_write_data.WREADY) begin
        if (beat == LAST_BEAT) state_nxt = RESP;
        else                   beat_nxt  = beat + 3'd1;
      end
      RESP: if (mem_write_response.BVALID) begin
        pop       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wdata = '0;
    for (int k = 0; k < LINE_WORDS; k++)
      if (beat == 3'(k)) wdata = head_data[k*`DATA_WIDTH +: `DATA_WIDTH];
  end

  // Channel outputs decode registered state only; payloads read 0 when idle.
  assign mem_write_address.AWVALID = (state == ADDR);
  assign mem_write_address.AWADDR  = (state == ADDR) ? head_addr : '0;
  assign mem_write_address.AWLEN   = (state == ADDR) ? AXI_LEN_W'(LINE_WORDS - 1) : '0;
  assign mem_write_address.AWID    = (state == ADDR) ? AXI_ID_W'(WB_ID) : '0;

  assign mem_write_data.WVALID = (state == DATA);
  assign mem_write_data.WDATA  = (state == DATA) ? wdata : '0;
  assign mem_write_data.WID    = (state == DATA) ? AXI_ID_W'(WB_ID) : '0;
  assign mem_write_data.WLAST  = (state == DATA) && (beat == LAST_BEAT);

  assign mem_write_response.BREADY = (state == RESP);
endmodule

// File: tb/tb_writeback_buffer.sv
// Directed self-checking bench for writeback_buffer (LINE_WORDS=4, DEPTH=2).
module tb_writeback_buffer;
  localparam int LW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wb_valid, wb_ready, lookup_hit;
  logic [31:0]    wb_addr, lookup_addr;
  logic [LW*32-1:0] wb_data, lookup_data;

  axi_write_address  aw_if ();
  axi_write_data     w_if ();
  axi_write_response b_if ();

  writeback_buffer #(.LINE_WORDS(LW), .DEPTH(2), .WB_ID(0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wb_valid          (wb_valid),
    .wb_ready          (wb_ready),
    .wb_addr           (wb_addr),
    .wb_data           (wb_data),
    .lookup_addr       (lookup_addr),
    .lookup_hit        (lookup_hit),
    .lookup_data       (lookup_data),
    .mem_write_address (aw_if),
    .mem_write_data    (w_if),
    .mem_write_response(b_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] aw_q[$];
  logic [32:0] w_q[$];

  // Handshake recorder
  always @(posedge clk) begin
    if (rst_n) begin
      if (aw_if.AWVALID && aw_if.AWREADY) aw_q.push_back(aw_if.AWADDR);
      if (w_if.WVALID && w_if.WREADY) w_q.push_back({w_if.WLAST, w_if.WDATA});
    end
  end

  localparam logic [127:0] D1 = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] DA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] DB = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [127:0] d);
    wb_addr  = a;
    wb_data  = d;
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
  endtask

  // Serves one burst: optional AWREADY stall, optional WREADY toggling, then B.
  task automatic drain(input int aw_stall, input bit w_toggle,
                       input logic [31:0] exp_addr, output int cyc);
    int t;
    logic [31:0] hold;
    bit hv;
    t = 0;
    aw_if.AWREADY = (aw_stall == 0);
    while (!aw_if.AWVALID && t < 50) begin tick(); t++; end
    chk("aw_valid", aw_if.AWVALID, 1'b1);
    chk("aw_addr", aw_if.AWADDR, exp_addr);
    chk("aw_len", aw_if.AWLEN, 4'd3);
    chk("aw_id", aw_if.AWID, 4'd0);
    for (int i = 0; i < aw_stall; i++) begin
      tick();
      chk("aw_hold_valid", aw_if.AWVALID, 1'b1);
      chk("aw_hold_addr", aw_if.AWADDR, exp_addr);
    end
    aw_if.AWREADY = 1'b1;
    tick();
    aw_if.AWREADY = 1'b0;
    t = 0;
    while (!b_if.BREADY && t < 100) begin
      w_if.WREADY = w_toggle ? t[0] : 1'b1;
      hv = w_if.WVALID && !w_if.WREADY;
      hold = w_if.WDATA;
      tick();
      t++;
      if (hv) chk("w_hold", w_if.WDATA, hold);
    end
    chk("b_ready", b_if.BREADY, 1'b1);
    cyc = t;
    w_if.WREADY = 1'b0;
    b_if.BVALID = 1'b1;
    tick();
    b_if.BVALID = 1'b0;
  endtask

  task automatic chk_beats();
    chk("beat_cnt", 128'(w_q.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      chk("beat", (i < w_q.size()) ? w_q[i] : 33'h0, {(i == 3), D1[i*32 +: 32]});
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; lookup_addr = 32'h1000;
    aw_if.AWREADY = 1'b0; w_if.WREADY = 1'b0; b_if.BVALID = 1'b0; b_if.BID = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_ready", wb_ready, 1'b1);
    chk("rst_hit", lookup_hit, 1'b0);
    chk("rst_data", lookup_data, '0);
    chk("rst_awvalid", aw_if.AWVALID, 1'b0);
    chk("rst_awaddr", aw_if.AWADDR, 32'h0);
    chk("rst_wvalid", w_if.WVALID, 1'b0);
    chk("rst_wlast", w_if.WLAST, 1'b0);
    chk("rst_wdata", w_if.WDATA, 32'h0);
    chk("rst_bready", b_if.BREADY, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single line, all READY high, minimum drain timing
    push(32'h1000, D1);
    chk("t1_hit", lookup_hit, 1'b1);
    drain(0, 1'b0, 32'h1000, cyc);
    chk("t1_w_cycles", 128'(cyc), 128'd4);
    chk_beats();
    chk("t1_ready_after", wb_ready, 1'b1);
    chk("t1_hit_after", lookup_hit, 1'b0);
    chk("t1_bready_after", b_if.BREADY, 1'b0);

    // Fill to DEPTH and check in-order drain
    aw_q.delete(); w_q.delete();
    push(32'h1000, D1);
    push(32'h2000, DA);
    chk("t2_full", wb_ready, 1'b0);
    lookup_addr = 32'h2008; #1;
    chk("t2_hit2000", lookup_hit, 1'b1);
    drain(0, 1'b0, 32'h1000, cyc);
    chk("t2_ready_after_b", wb_ready, 1'b1);
    push(32'h3000, DB);
    drain(0, 1'b0, 32'h2000, cyc);
    drain(0, 1'b0, 32'h3000, cyc);
    chk("t2_aw_cnt", 128'(aw_q.size()), 128'd3);
    chk("t2_aw0", aw_q.size() > 0 ? aw_q[0] : 32'h0, 32'h1000);
    chk("t2_aw1", aw_q.size() > 1 ? aw_q[1] : 32'h0, 32'h2000);
    chk("t2_aw2", aw_q.size() > 2 ? aw_q[2] : 32'h0, 32'h3000);

    // AWREADY stall and WREADY toggling
    aw_q.delete(); w_q.delete();
    push(32'h1000, D1);
    drain(5, 1'b1, 32'h1000, cyc);
    chk_beats();

    // Duplicate line: youngest copy wins until its own response
    push(32'h1000, DA);
    push(32'h1000, DB);
    lookup_addr = 32'h1004; #1;
    chk("t4_hit", lookup_hit, 1'b1);
`ifdef WRITEBACK_FORWARD_EN
    chk("t4_data", lookup_data, DB);
`else
    chk("t4_data", lookup_data, '0);
`endif
    lookup_addr = 32'h2000; #1;
    chk("t4_miss", lookup_hit, 1'b0);
    lookup_addr = 32'h1004;
    drain(0, 1'b0, 32'h1000, cyc);
    chk("t4_hit_mid", lookup_hit, 1'b1);
`ifdef WRITEBACK_FORWARD_EN
    chk("t4_data_mid", lookup_data, DB);
`endif
    drain(0, 1'b0, 32'h1000, cyc);
    chk("t4_hit_end", lookup_hit, 1'b0);

    // Reset during beat 2
    aw_q.delete(); w_q.delete();
    push(32'h1000, D1);
    aw_if.AWREADY = 1'b1;
    cyc = 0;
    while (!aw_if.AWVALID && cyc < 20) begin tick(); cyc++; end
    chk("t5_aw", aw_if.AWVALID, 1'b1);
    tick();
    aw_if.AWREADY = 1'b0;
    w_if.WREADY = 1'b1;
    tick();
    tick();
    w_if.WREADY = 1'b0;
    chk("t5_beat2", w_if.WDATA, 32'h33);
    lookup_addr = 32'h1000;
    rst_n = 1'b0;
    #1;
    chk("t5_awvalid", aw_if.AWVALID, 1'b0);
    chk("t5_awaddr", aw_if.AWADDR, 32'h0);
    chk("t5_wvalid", w_if.WVALID, 1'b0);
    chk("t5_wlast", w_if.WLAST, 1'b0);
    chk("t5_wdata", w_if.WDATA, 32'h0);
    chk("t5_bready", b_if.BREADY, 1'b0);
    chk("t5_hit", lookup_hit, 1'b0);
    chk("t5_ready", wb_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_idle_aw", aw_if.AWVALID, 1'b0);
    end
    chk("t5_ready_after", wb_ready, 1'b1);
    aw_q.delete(); w_q.delete();
    push(32'h5000, D1);
    drain(0, 1'b0, 32'h5000, cyc);
    chk("t5_aw_cnt", 128'(aw_q.size()), 128'd1);
    chk_beats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
